// File: rtl/arb_pkg.sv
// Shared arbiter types, defaults and helpers.
// Used by wrr_arbiter (optional ARB_LOCK_EN) and arb_rr_pick.
package arb_pkg;

  localparam int ARB_N        = 8;
  localparam int ARB_WEIGHT_W = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  function automatic int onehot2idx(
    input logic [31:0] oh
  );
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational masked round-robin picker.
// First set req bit at or above ptr, wrapping modulo N.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int N = ARB_N
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] win
);

  logic [2*N-1:0] dreq;
  logic [2*N-1:0] dsel;

  always_comb begin
    dreq = {req, req};
    // subtracting ptr clears the first set bit at or above ptr
    dsel = dreq & ~(dreq - {{N{1'b0}}, ptr});
    win  = dsel[N-1:0] | dsel[2*N-1:N];
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with burst-holding grants.
// Define ARB_LOCK_EN to add the lock port.
module wrr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int WEIGHT_W = ARB_WEIGHT_W,
  localparam int IW      = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic [N*WEIGHT_W-1:0] weight,
`ifdef ARB_LOCK_EN
  input  logic                  lock,
`endif
  output logic [N-1:0]          grant,
  output logic [IW-1:0]         grant_idx,
  output logic                  grant_vld
);

  arb_state_t          state;
  logic [N-1:0]        ptr;
  logic [WEIGHT_W-1:0] credit;

  logic [N-1:0]        win;
  logic [31:0]         win32;
  logic [IW-1:0]       win_idx;
  logic [WEIGHT_W-1:0] wsel;
  logic [WEIGHT_W-1:0] wload;
  logic                more;
  logic                hold;

  arb_rr_pick #(.N(N)) u_pick (
    .req (req),
    .ptr (ptr),
    .win (win)
  );

  always_comb begin
    win32        = '0;
    win32[N-1:0] = win;
    win_idx      = IW'(onehot2idx(win32));
    wsel         = '0;
    for (int i = 0; i < N; i++) begin
      if (win[i]) wsel = wsel | weight[i*WEIGHT_W +: WEIGHT_W];
    end
    wload = (wsel == '0) ? WEIGHT_W'(1) : wsel;
    more  = credit > WEIGHT_W'(1);
`ifdef ARB_LOCK_EN
    hold  = |(req & grant) && (more || lock);
`else
    hold  = |(req & grant) && more;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      ptr       <= N'(1);
      credit    <= '0;
      grant     <= '0;
      grant_idx <= '0;
      grant_vld <= 1'b0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (|req) begin
            state     <= ARB_BUSY;
            grant     <= win;
            grant_idx <= win_idx;
            grant_vld <= 1'b1;
            credit    <= wload;
            ptr       <= {win[N-2:0], win[N-1]};
          end
        end
        ARB_BUSY: begin
          if (hold) begin
            if (more) credit <= credit - WEIGHT_W'(1);
          end else if (|req) begin
            // ptr already sits past the owner, so it loses ties
            grant     <= win;
            grant_idx <= win_idx;
            grant_vld <= 1'b1;
            credit    <= wload;
            ptr       <= {win[N-2:0], win[N-1]};
          end else begin
            state     <= ARB_IDLE;
            grant     <= '0;
            grant_idx <= '0;
            grant_vld <= 1'b0;
            credit    <= '0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter (N=4).
// Builds with or without ARB_LOCK_EN.
module tb_wrr_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;
  localparam int IW = 2;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct {
    logic [N-1:0]    req;
    logic [N*WW-1:0] weight;
    logic            lock;
    logic [N-1:0]    exp;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*WW-1:0] weight = '0;
  logic            lock = 1'b0;
  logic [N-1:0]    grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_vld;

  int vectors = 0;
  int miscompares = 0;

  int m_own = -1;
  int m_left = 0;
  int m_ptr = 0;

  vec_t tbl[12];

  always #5 clk = ~clk;

  wrr_arbiter #(.N(N), .WEIGHT_W(WW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .weight    (weight),
`ifdef ARB_LOCK_EN
    .lock      (lock),
`endif
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  function automatic void m_reset();
    m_own  = -1;
    m_left = 0;
    m_ptr  = 0;
  endfunction

  function automatic void m_step();
    bit lk;
    int k;
    int w;
    lk = LOCK_EN && lock;
    if (m_own >= 0 && req[m_own] && (m_left > 1 || lk)) begin
      if (m_left > 1) m_left--;
    end else begin
      k = -1;
      for (int i = 0; i < N; i++) begin
        if (k < 0 && req[(m_ptr + i) % N]) k = (m_ptr + i) % N;
      end
      m_own = k;
      if (k >= 0) begin
        w      = int'(weight[k*WW +: WW]);
        m_left = (w == 0) ? 1 : w;
        m_ptr  = (k + 1) % N;
      end
    end
  endfunction

  task automatic check(input string nm);
    logic [N-1:0]  one;
    logic [N-1:0]  eg;
    logic [IW-1:0] ei;
    logic          ev;
    one = 1;
    eg  = (m_own >= 0) ? (one << m_own) : '0;
    ei  = (m_own >= 0) ? IW'(m_own) : '0;
    ev  = (m_own >= 0);
    vectors++;
    if (grant !== eg || grant_idx !== ei || grant_vld !== ev) begin
      miscompares++;
      $display("FAIL %s t=%0t: got grant=%b idx=%0d vld=%b, want grant=%b idx=%0d vld=%b",
               nm, $time, grant, grant_idx, grant_vld, eg, ei, ev);
    end
  endtask

  task automatic chk_grant(input string nm, input logic [N-1:0] exp);
    vectors++;
    if (grant !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got grant=%b, want %b", nm, $time, grant, exp);
    end
  endtask

  task automatic tick(input string nm);
    @(posedge clk);
    m_step();
    #1;
    check(nm);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check("async_rst");
    repeat (2) begin
      @(posedge clk);
      #1;
      check("in_rst");
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 12; i++) begin
      tbl[i].req    = 4'b1111;
      tbl[i].weight = 16'h4321;
      tbl[i].lock   = 1'b0;
    end
    tbl[0].exp  = 4'b0001;
    tbl[1].exp  = 4'b0010;
    tbl[2].exp  = 4'b0010;
    tbl[3].exp  = 4'b0100;
    tbl[4].exp  = 4'b0100;
    tbl[5].exp  = 4'b0100;
    tbl[6].exp  = 4'b1000;
    tbl[7].exp  = 4'b1000;
    tbl[8].exp  = 4'b1000;
    tbl[9].exp  = 4'b1000;
    tbl[10].exp = 4'b0001;
    tbl[11].exp = 4'b0010;

    req    = 4'b1111;
    weight = 16'h4321;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      req    = tbl[i].req;
      weight = tbl[i].weight;
      lock   = tbl[i].lock;
      tick("rot");
      chk_grant("rot_tbl", tbl[i].exp);
    end

    do_reset();
    req    = 4'b0100;
    weight = 16'h0300;
    for (int i = 0; i < 9; i++) begin
      tick("single");
      chk_grant("single_tbl", 4'b0100);
    end
    req = '0;
    tick("single_end");
    chk_grant("single_end_tbl", 4'b0000);

    do_reset();
    weight = 16'h0040;
    req    = 4'b0010;
    tick("drop_a");
    chk_grant("drop_a_tbl", 4'b0010);
    req = 4'b1010;
    tick("drop_b");
    chk_grant("drop_b_tbl", 4'b0010);
    req = 4'b1000;
    tick("drop_c");
    chk_grant("drop_c_tbl", 4'b1000);

    do_reset();
    weight = '0;
    req    = 4'b0001;
    tick("w0_a");
    chk_grant("w0_a_tbl", 4'b0001);
    req = '0;
    tick("w0_b");
    chk_grant("w0_b_tbl", 4'b0000);
    tick("w0_c");
    chk_grant("w0_c_tbl", 4'b0000);

`ifdef ARB_LOCK_EN
    do_reset();
    weight = 16'h0011;
    req    = 4'b0011;
    lock   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("lock_hold");
      chk_grant("lock_hold_tbl", 4'b0001);
    end
    lock = 1'b0;
    tick("lock_rel");
    chk_grant("lock_rel_tbl", 4'b0010);
`endif

    lock = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      if ($urandom_range(0, 15) == 0) weight = (N*WW)'($urandom);
      lock = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
